// File: rtl/hamming_secded_enc_pipe_pkg.sv
// hamming_pkg: width helpers and the shared SECDED encode function
package hamming_pkg;
  localparam int MAX_DATA_W = 57;
  localparam int MAX_CODE_W = 64;
  localparam int MAX_PAR_W = 6;

  function automatic int calc_par_w(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < data_w + r + 1) r++;
    return r;
  endfunction

  function automatic int code_w(input int data_w);
    return data_w + calc_par_w(data_w) + 1;
  endfunction

  function automatic logic is_pow2(input int pos);
    return pos > 0 && (pos & (pos - 1)) == 0;
  endfunction

  // Result is zero-extended to MAX_CODE_W; callers truncate to their own width.
  function automatic logic [MAX_CODE_W-1:0] encode(input logic [MAX_DATA_W-1:0] data,
                                                   input int data_w, input logic secded_en);
    logic [MAX_CODE_W-1:0] cw;
    int cw_w, par_w, d;
    logic p;
    cw_w = code_w(data_w);
    par_w = calc_par_w(data_w);
    cw = '0;
    d = 0;
    for (int k = 1; k < MAX_CODE_W; k++)
      if (k < cw_w && !is_pow2(k)) begin
        cw[6'(k - 1)] = data[6'(d)];
        d++;
      end
    for (int j = 0; j < MAX_PAR_W; j++) begin
      p = 1'b0;
      for (int k = 1; k < MAX_CODE_W; k++)
        if (k < cw_w && ((k >> j) & 1) != 0) p ^= cw[6'(k - 1)];
      if (j < par_w) cw[6'((1 << j) - 1)] = p;
    end
    cw[6'(cw_w - 1)] = secded_en & (^cw);
    return cw;
  endfunction
endpackage

// File: rtl/hamming_secded_enc_pipe_if.sv
// hamming_secded_enc_pipe_if: producer/consumer stream bundle of the encoder pipe
interface hamming_secded_enc_pipe_if #(parameter int DATA_W = 8, parameter int CNT_W = 16);
  localparam int CODE_W = hamming_pkg::code_w(DATA_W);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] data_in;
  logic secded_en;
  logic [CODE_W-1:0] inj_mask;
  logic out_valid;
  logic out_ready;
  logic [CODE_W-1:0] encoded_out;
  logic [CNT_W-1:0] words_out;
  modport master (output in_valid, data_in, secded_en, inj_mask, out_ready,
                  input in_ready, out_valid, encoded_out, words_out);
  modport slave (input in_valid, data_in, secded_en, inj_mask, out_ready,
                 output in_ready, out_valid, encoded_out, words_out);
endinterface

// File: rtl/hamming_secded_enc_pipe_core.sv
// hamming_secded_enc_core: combinational DATA_W -> CODE_W SECDED encoder
module hamming_secded_enc_core
  import hamming_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CODE_W = code_w(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  input  logic              secded_en,
  output logic [CODE_W-1:0] code
);
  assign code = CODE_W'(encode(MAX_DATA_W'(data), DATA_W, secded_en));
endmodule

// File: rtl/hamming_secded_enc_pipe.sv
// hamming_secded_enc_pipe: two-stage valid/ready SECDED encoder with injection and word count
module hamming_secded_enc_pipe
  import hamming_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  hamming_secded_enc_pipe_if.slave bus
);
  localparam int PAR_W = calc_par_w(DATA_W);
  localparam int CODE_W = DATA_W + PAR_W + 1;
  logic s1_v;
  logic [DATA_W-1:0] s1_data;
  logic [CODE_W-1:0] code;
  logic adv2, accept, handoff;
  assign adv2 = s1_v & (~bus.out_valid | bus.out_ready);
  assign bus.in_ready = ~s1_v | adv2;
  assign accept = bus.in_valid & bus.in_ready;
  assign handoff = bus.out_valid & bus.out_ready;
  hamming_secded_enc_core #(.DATA_W(DATA_W), .CODE_W(CODE_W)) u_core (
    .data(s1_data),
    .secded_en(bus.secded_en),
    .code(code)
  );
  // secded_en and inj_mask only matter in the cycle a word moves S1 -> S2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_data <= '0;
      bus.out_valid <= 1'b0;
      bus.encoded_out <= '0;
      bus.words_out <= '0;
    end else begin
      if (accept) begin
        s1_v <= 1'b1;
        s1_data <= bus.data_in;
      end else if (adv2) s1_v <= 1'b0;
      if (adv2) begin
        bus.out_valid <= 1'b1;
        bus.encoded_out <= code ^ bus.inj_mask;
      end else if (handoff) bus.out_valid <= 1'b0;
      if (handoff) bus.words_out <= bus.words_out + CNT_W'(1);
    end
  end
endmodule
